// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl: drives one external mac instance through a signed dot product of len operand pairs
// and returns the final accumulator on a valid/ready result port. abort cancels from any state.
module mac_dot_ctrl #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 32,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              abort,
   output logic              busy,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              mac_en,
   output logic              mac_clear,
   output logic [DATA_W-1:0] mac_a,
   output logic [DATA_W-1:0] mac_b,
   input  logic [ACC_W-1:0]  mac_acc,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic [2:0]        state_dbg
);

   // Handshakes (op_*, res_*): a transfer happens on a rising edge where valid and ready are both
   // high; the sender holds payload stable until then. abort suppresses both readies/valids.

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [LEN_W-1:0] ONE = 1;

   state_t           state;
   state_t           state_nx;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q;
   logic [LEN_W-1:0] cnt_inc;
   logic             load;
   logic             beat;
   logic             capture;

   assign cnt_inc   = cnt_q + ONE;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         res_data <= '0;
      end else begin
         state <= state_nx;
         if (load) begin
            len_q <= len;
            cnt_q <= '0;
         end else if (beat) begin
            cnt_q <= cnt_inc;
         end
         if (capture) begin
            res_data <= mac_acc;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      busy      = (state != IDLE);
      op_ready  = 1'b0;
      mac_en    = 1'b0;
      mac_clear = 1'b0;
      mac_a     = '0;
      mac_b     = '0;
      res_valid = 1'b0;
      load      = 1'b0;
      beat      = 1'b0;
      capture   = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               state_nx = CLEAR;
            end
         end
         CLEAR: begin
            mac_clear = 1'b1;
            state_nx  = (len_q != '0) ? RUN : DRAIN;
         end
         RUN: begin
            op_ready = 1'b1;
            if (op_valid) begin
               mac_en = 1'b1;
               mac_a  = op_a;
               mac_b  = op_b;
               beat   = 1'b1;
               if (cnt_inc == len_q) begin
                  state_nx = DRAIN;
               end
            end
         end
         DRAIN: begin
            // The final beat was added to mac_acc on the edge that entered DRAIN.
            capture  = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      // abort wins over everything; the MAC is left as-is for the next CLEAR to wipe.
      if (abort) begin
         state_nx  = IDLE;
         op_ready  = 1'b0;
         mac_en    = 1'b0;
         mac_clear = 1'b0;
         mac_a     = '0;
         mac_b     = '0;
         res_valid = 1'b0;
         load      = 1'b0;
         beat      = 1'b0;
         capture   = 1'b0;
      end
   end

endmodule
